// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
//   Shares one FP16 x INT4 multiplier pipeline among NUM_REQ requesters.
//   Round-robin arbitration on the request side. A tag FIFO remembers which
//   requester issued each in-flight operation. Results therefore go back to
//   their issuer, in issue order. The arbiter adds no latency in either
//   direction.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/ready     per-requester operation handshake
//   req_fp16, req_int4  packed operands, requester i at [16i+:16] / [4i+:4]
//   rsp_valid/ready     per-requester result handshake (rsp_valid one-hot or 0)
//   rsp_fp16            result data, shared by all requesters
//   mul_in_*            issue side of the multiplier
//   mul_out_*           result side of the multiplier
//   idle                tag FIFO empty and no request pending
//   proto_err           sticky: multiplier produced a result with no tag outstanding
//
// Optional build macro FP_MUL_ARB_STATS_EN
//   Adds the stat_issue_cnt (16 bits per requester) and stat_stall_cnt ports.
//   Both are saturating counters.

module fp_mul_arbiter #(
   parameter  int NUM_REQ   = 4,
   parameter  int TAG_DEPTH = 4,
   localparam int TAG_W     = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [16*NUM_REQ-1:0]  req_fp16,
   input  logic [4*NUM_REQ-1:0]   req_int4,
   output logic [NUM_REQ-1:0]     rsp_valid,
   input  logic [NUM_REQ-1:0]     rsp_ready,
   output logic [15:0]            rsp_fp16,
   output logic                   mul_in_valid,
   input  logic                   mul_in_ready,
   output logic [15:0]            mul_in_fp16,
   output logic [3:0]             mul_in_int4,
   input  logic                   mul_out_valid,
   output logic                   mul_out_ready,
   input  logic [15:0]            mul_out_fp16,
`ifdef FP_MUL_ARB_STATS_EN
   output logic [16*NUM_REQ-1:0]  stat_issue_cnt,
   output logic [15:0]            stat_stall_cnt,
`endif
   output logic                   idle,
   output logic                   proto_err
);

   localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

   logic [TAG_W-1:0] prio, grant, next_prio, head;
   logic             any_valid, found, full, empty, can_issue, issue, pop;
   logic [TAG_W:0]   sum;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic [TAG_W-1:0] tag_mem [TAG_DEPTH];

   assign any_valid = |req_valid;
   assign empty     = (count == '0);
   assign full      = (count == (PTR_W+1)'(TAG_DEPTH));
   assign head      = tag_mem[rd_ptr];

   // Rotating-priority search: the first valid at or after prio, with wrap.
   always_comb begin
      grant = '0;
      found = 1'b0;
      sum   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, prio} + (TAG_W+1)'(k);
         if (sum >= (TAG_W+1)'(NUM_REQ)) sum = sum - (TAG_W+1)'(NUM_REQ);
         if (!found && req_valid[sum[TAG_W-1:0]]) begin
            found = 1'b1;
            grant = sum[TAG_W-1:0];
         end
      end
   end

   assign next_prio = (grant == TAG_W'(NUM_REQ-1)) ? '0 : grant + TAG_W'(1);

   // Response side depends only on the FIFO head and rsp_ready, never on req_valid.
   assign mul_out_ready = !empty && rsp_ready[head];
   assign pop           = mul_out_valid && mul_out_ready;
   assign rsp_fp16      = mul_out_fp16;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept an issue.
   assign can_issue    = !full || pop;
   assign mul_in_valid = any_valid && can_issue;
   assign issue        = mul_in_valid && mul_in_ready;
   assign idle         = empty && !any_valid;

   always_comb begin
      req_ready   = '0;
      rsp_valid   = '0;
      mul_in_fp16 = '0;
      mul_in_int4 = '0;
      if (any_valid) req_ready[grant] = mul_in_ready && can_issue;
      rsp_valid[head] = mul_out_valid && !empty;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (any_valid && grant == TAG_W'(i)) begin
            mul_in_fp16 = req_fp16[16*i +: 16];
            mul_in_int4 = req_int4[4*i +: 4];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio      <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         proto_err <= 1'b0;
      end else begin
         if (issue) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            prio   <= next_prio;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({issue, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
         if (mul_out_valid && empty) proto_err <= 1'b1;
      end
   end

   // Tag storage needs no reset: entries are only read when count says they are live.
   always_ff @(posedge clk) begin
      if (issue) tag_mem[wr_ptr] <= grant;
   end

`ifdef FP_MUL_ARB_STATS_EN
   logic [15:0] issue_cnt [NUM_REQ];
   logic [15:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) issue_cnt[i] <= '0;
         stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (issue && grant == TAG_W'(i) && issue_cnt[i] != 16'hFFFF)
               issue_cnt[i] <= issue_cnt[i] + 16'd1;
         end
         if (any_valid && !issue && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
      assign stat_issue_cnt[16*i +: 16] = issue_cnt[i];
   end
   assign stat_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
module tb_fp_mul_arbiter;
   localparam int NR  = 4;
   localparam int TD  = 4;
   localparam int LAT = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
   logic [16*NR-1:0]  req_fp16;
   logic [4*NR-1:0]   req_int4;
   logic [15:0]       rsp_fp16, mul_in_fp16, mul_out_fp16;
   logic [3:0]        mul_in_int4;
   logic              mul_in_valid, mul_in_ready, mul_out_valid, mul_out_ready;
   logic              idle, proto_err;
`ifdef FP_MUL_ARB_STATS_EN
   logic [16*NR-1:0]  stat_issue_cnt;
   logic [15:0]       stat_stall_cnt;
`endif

   fp_mul_arbiter #(.NUM_REQ(NR), .TAG_DEPTH(TD)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_fp16(req_fp16), .req_int4(req_int4),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_fp16(rsp_fp16),
      .mul_in_valid(mul_in_valid), .mul_in_ready(mul_in_ready),
      .mul_in_fp16(mul_in_fp16), .mul_in_int4(mul_in_int4),
      .mul_out_valid(mul_out_valid), .mul_out_ready(mul_out_ready),
      .mul_out_fp16(mul_out_fp16),
`ifdef FP_MUL_ARB_STATS_EN
      .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt),
`endif
      .idle(idle), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   // FP16 x signed INT4 for normal operands (mantissa truncated).
   function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [3:0] b);
      int k, e;
      int unsigned m;
      logic s;
      logic [15:0] res;
      k = int'($signed(b));
      s = a[15] ^ (k < 0);
      if (k < 0) k = -k;
      if (k == 0 || a[14:10] == 5'd0) res = {s, 15'd0};
      else begin
         m = int'({1'b1, a[9:0]}) * k;
         e = int'(a[14:10]);
         while (m >= 2048) begin m = m >> 1; e++; end
         if (e >= 31) res = {s, 5'h1F, 10'd0};
         else res = {s, e[4:0], m[9:0]};
      end
      return res;
   endfunction

   // Multiplier model: up to 4 in flight, fixed latency LAT, in order.
   logic [15:0] mq_d [4];
   int          mq_t [4];
   int          mq_rd, mq_wr, mq_cnt, cyc;
   logic        model_v, out_fire, mul_en, force_mov;

   always_comb begin
      model_v = (mq_cnt != 0) && ((cyc - mq_t[mq_rd]) >= LAT);
   end
   assign mul_out_valid = model_v | force_mov;
   assign mul_out_fp16  = mq_d[mq_rd];
   assign out_fire      = model_v & mul_out_ready;
   assign mul_in_ready  = mul_en & ((mq_cnt < 4) | out_fire);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         mq_rd  <= 0;
         mq_wr  <= 0;
         mq_cnt <= 0;
      end else begin
         if (mul_in_valid && mul_in_ready) begin
            mq_d[mq_wr] <= fp16_mul(mul_in_fp16, mul_in_int4);
            mq_t[mq_wr] <= cyc;
            mq_wr       <= (mq_wr + 1) % 4;
         end
         if (out_fire) mq_rd <= (mq_rd + 1) % 4;
         mq_cnt <= mq_cnt + ((mul_in_valid && mul_in_ready) ? 1 : 0) - (out_fire ? 1 : 0);
      end
   end

   // Requester stimulus tables and scoreboard state.
   typedef struct { int r; logic [15:0] d; } exp_t;
   exp_t        sb [$];
   int          grant_log [$];
   logic [15:0] fp_tab [NR][8];
   logic [3:0]  i4_tab [NR][8];
   int          n_ops [NR];
   int          idx [NR];
   int          rsp_cnt [NR];
   int          rsp_cyc [NR];
   logic [15:0] rsp_last [NR];
   logic [NR-1:0] acc;
   int          errs, chks, n_issue, tcyc, issue_cyc;

   task automatic add_op(input int r, input logic [15:0] f, input logic [3:0] b);
      fp_tab[r][n_ops[r]] = f;
      i4_tab[r][n_ops[r]] = b;
      n_ops[r]++;
   endtask

   task automatic drive();
      for (int r = 0; r < NR; r++) begin
         if (idx[r] < n_ops[r]) begin
            req_valid[r]          = 1'b1;
            req_fp16[16*r +: 16]  = fp_tab[r][idx[r]];
            req_int4[4*r +: 4]    = i4_tab[r][idx[r]];
         end else begin
            req_valid[r]          = 1'b0;
            req_fp16[16*r +: 16]  = '0;
            req_int4[4*r +: 4]    = '0;
         end
      end
   endtask

   task automatic clear_ops();
      for (int r = 0; r < NR; r++) begin n_ops[r] = 0; idx[r] = 0; end
      drive();
   endtask

   // Scoreboard: push on accepted request, pop/compare on accepted response.
   task automatic sample();
      exp_t e;
      acc = '0;
      if (!rst_n) begin sb.delete(); return; end
      acc = req_valid & req_ready;
      if (mul_in_valid && mul_in_ready) begin
         n_issue++;
         issue_cyc = tcyc;
         for (int r = 0; r < NR; r++) begin
            if (acc[r]) begin
               grant_log.push_back(r);
               e.r = r;
               e.d = fp16_mul(fp_tab[r][idx[r]], i4_tab[r][idx[r]]);
               sb.push_back(e);
               chks++;
               if (mul_in_fp16 !== fp_tab[r][idx[r]] || mul_in_int4 !== i4_tab[r][idx[r]]) begin
                  errs++;
                  $display("FAIL issue_operands req%0d: got %h/%h want %h/%h", r, mul_in_fp16,
                           mul_in_int4, fp_tab[r][idx[r]], i4_tab[r][idx[r]]);
               end
            end
         end
      end
      if (rsp_valid != '0) begin
         chks++;
         if (!$onehot(rsp_valid)) begin
            errs++;
            $display("FAIL rsp_onehot: got %b want one-hot", rsp_valid);
         end
      end
      for (int r = 0; r < NR; r++) begin
         if (rsp_valid[r] && rsp_ready[r]) begin
            chks++;
            if (sb.size() == 0) begin
               errs++;
               $display("FAIL rsp_unexpected req%0d: got %h want no response", r, rsp_fp16);
            end else begin
               e = sb.pop_front();
               if (e.r != r || e.d !== rsp_fp16) begin
                  errs++;
                  $display("FAIL rsp_order: got req%0d %h want req%0d %h", r, rsp_fp16, e.r, e.d);
               end
            end
            rsp_cnt[r]++;
            rsp_cyc[r]  = tcyc;
            rsp_last[r] = rsp_fp16;
         end
      end
   endtask

   // One cycle: sample at negedge, then advance and drive just after posedge.
   task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      tcyc++;
      for (int r = 0; r < NR; r++) if (acc[r]) idx[r]++;
      drive();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_ops();
      repeat (2) step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rsp_ready = '1;
      do_reset();
      chks++; if (req_ready !== '0) begin errs++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      chks++; if (rsp_valid !== '0) begin errs++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      chks++; if (mul_in_valid !== 1'b0) begin errs++; $display("FAIL reset_mul_in_valid: got %b want 0", mul_in_valid); end
      chks++; if (mul_out_ready !== 1'b0) begin errs++; $display("FAIL reset_mul_out_ready: got %b want 0", mul_out_ready); end
      chks++; if (idle !== 1'b1) begin errs++; $display("FAIL reset_idle: got %b want 1", idle); end
      chks++; if (proto_err !== 1'b0) begin errs++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
   endtask

   task automatic test_single_op();
      do_reset();
      rsp_ready = '1;
      add_op(2, 16'h3C00, 4'h2);
      drive();
      #1;
      chks++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL single_req_ready: got %b want 0100", req_ready); end
      chks++; if (mul_in_valid !== 1'b1) begin errs++; $display("FAIL single_mul_in_valid: got %b want 1", mul_in_valid); end
      for (int i = 0; i < 20; i++) begin
         step();
         #1;
         if (rsp_valid != '0) break;
      end
      chks++; if (rsp_valid !== 4'b0100) begin errs++; $display("FAIL single_rsp_valid: got %b want 0100", rsp_valid); end
      chks++; if (rsp_fp16 !== 16'h4000) begin errs++; $display("FAIL single_rsp_fp16: got %h want 4000", rsp_fp16); end
      chks++; if (tcyc - issue_cyc != LAT) begin errs++; $display("FAIL single_latency: got %0d want %0d", tcyc - issue_cyc, LAT); end
      for (int i = 0; i < 10; i++) begin
         step();
         #1;
         if (idle) break;
      end
      chks++; if (idle !== 1'b1) begin errs++; $display("FAIL single_idle: got %b want 1", idle); end
   endtask

   task automatic test_round_robin();
      int base [NR];
      int total;
      do_reset();
      rsp_ready = '1;
      grant_log.delete();
      for (int r = 0; r < NR; r++) begin
         base[r] = rsp_cnt[r];
         for (int j = 0; j < 2; j++) add_op(r, {1'b0, 5'(14 + j), 10'(r * 64 + j)}, 4'(r + 1 + j));
      end
      drive();
      for (int i = 0; i < 60; i++) begin
         total = 0;
         for (int r = 0; r < NR; r++) total += rsp_cnt[r] - base[r];
         if (total == 8) break;
         step();
      end
      chks++;
      if (grant_log.size() != 8) begin
         errs++;
         $display("FAIL rr_grant_count: got %0d want 8", grant_log.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            chks++;
            if (grant_log[i] != i % NR) begin
               errs++;
               $display("FAIL rr_grant_order[%0d]: got %0d want %0d", i, grant_log[i], i % NR);
            end
         end
      end
      for (int r = 0; r < NR; r++) begin
         chks++;
         if (rsp_cnt[r] - base[r] != 2) begin
            errs++;
            $display("FAIL rr_rsp_count req%0d: got %0d want 2", r, rsp_cnt[r] - base[r]);
         end
`ifdef FP_MUL_ARB_STATS_EN
         chks++;
         if (stat_issue_cnt[16*r +: 16] !== 16'd2) begin
            errs++;
            $display("FAIL rr_stat_issue req%0d: got %0d want 2", r, stat_issue_cnt[16*r +: 16]);
         end
`endif
      end
   endtask

   task automatic test_full();
      int base;
      do_reset();
      rsp_ready = '0;
      for (int r = 0; r < NR; r++)
         for (int j = 0; j < 3; j++) add_op(r, {1'b0, 5'd15, 10'(r * 8 + j)}, 4'(j + 1));
      drive();
      base = n_issue;
      repeat (10) step();
      #1;
      chks++; if (n_issue - base != TD) begin errs++; $display("FAIL full_issue_count: got %0d want %0d", n_issue - base, TD); end
      chks++; if (mul_in_valid !== 1'b0) begin errs++; $display("FAIL full_mul_in_valid: got %b want 0", mul_in_valid); end
      chks++; if (mul_out_ready !== 1'b0) begin errs++; $display("FAIL full_mul_out_ready: got %b want 0", mul_out_ready); end
      rsp_ready = '1;
      #1;
      chks++;
      if ({mul_out_ready, mul_in_valid, mul_in_ready} !== 3'b111) begin
         errs++;
         $display("FAIL full_issue_on_pop: got %b want 111", {mul_out_ready, mul_in_valid, mul_in_ready});
      end
      for (int i = 0; i < 100; i++) begin
         if (n_issue - base == 12 && sb.size() == 0) break;
         step();
      end
      #1;
      chks++; if (n_issue - base != 12) begin errs++; $display("FAIL full_total_issues: got %0d want 12", n_issue - base); end
      chks++; if (sb.size() != 0) begin errs++; $display("FAIL full_drain: got %0d pending want 0", sb.size()); end
      chks++; if (idle !== 1'b1) begin errs++; $display("FAIL full_idle: got %b want 1", idle); end
   endtask

   task automatic test_mixed_signs();
      int b0, b1;
      do_reset();
      rsp_ready = '1;
      b0 = rsp_cnt[0];
      b1 = rsp_cnt[1];
      add_op(0, 16'hC000, 4'hF);
      add_op(1, 16'h3C00, 4'h0);
      drive();
      for (int i = 0; i < 20; i++) begin
         if (rsp_cnt[0] != b0 && rsp_cnt[1] != b1) break;
         step();
      end
      chks++; if (rsp_cnt[0] - b0 != 1) begin errs++; $display("FAIL mixed_cnt0: got %0d want 1", rsp_cnt[0] - b0); end
      chks++; if (rsp_cnt[1] - b1 != 1) begin errs++; $display("FAIL mixed_cnt1: got %0d want 1", rsp_cnt[1] - b1); end
      chks++; if (rsp_last[0] !== 16'h4000) begin errs++; $display("FAIL mixed_rsp0: got %h want 4000", rsp_last[0]); end
      chks++; if (rsp_last[1] !== 16'h0000) begin errs++; $display("FAIL mixed_rsp1: got %h want 0000", rsp_last[1]); end
   endtask

   task automatic test_reset_midflight();
      int base;
      do_reset();
      rsp_ready = '0;
      add_op(0, 16'h3C00, 4'h3);
      add_op(1, 16'h4000, 4'h1);
      add_op(2, 16'h3800, 4'h2);
      drive();
      base = n_issue;
      for (int i = 0; i < 20; i++) begin
         if (n_issue - base == 3) break;
         step();
      end
      chks++; if (n_issue - base != 3) begin errs++; $display("FAIL midrst_issued: got %0d want 3", n_issue - base); end
      rst_n = 1'b0;
      clear_ops();
      step();
      rst_n = 1'b1;
      #1;
      chks++; if (rsp_valid !== '0) begin errs++; $display("FAIL midrst_rsp_valid: got %b want 0", rsp_valid); end
      chks++; if (idle !== 1'b1) begin errs++; $display("FAIL midrst_idle: got %b want 1", idle); end
      chks++; if (mul_out_ready !== 1'b0) begin errs++; $display("FAIL midrst_mul_out_ready: got %b want 0", mul_out_ready); end
      chks++; if (proto_err !== 1'b0) begin errs++; $display("FAIL midrst_proto_err: got %b want 0", proto_err); end
      rsp_ready = '1;
      add_op(3, 16'h3C00, 4'h1);
      add_op(0, 16'h3C00, 4'h2);
      drive();
      #1;
      chks++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL midrst_prio: got %b want 0001", req_ready); end
      for (int i = 0; i < 20; i++) begin
         if (idle && sb.size() == 0) break;
         step();
      end
      chks++; if (sb.size() != 0) begin errs++; $display("FAIL midrst_drain: got %0d pending want 0", sb.size()); end
   endtask

   task automatic test_proto_err();
      do_reset();
      rsp_ready = '1;
      force_mov = 1'b1;
      #1;
      chks++; if (mul_out_ready !== 1'b0) begin errs++; $display("FAIL proto_mul_out_ready: got %b want 0", mul_out_ready); end
      chks++; if (rsp_valid !== '0) begin errs++; $display("FAIL proto_rsp_valid: got %b want 0", rsp_valid); end
      step();
      force_mov = 1'b0;
      #1;
      chks++; if (proto_err !== 1'b1) begin errs++; $display("FAIL proto_set: got %b want 1", proto_err); end
      repeat (3) step();
      #1;
      chks++; if (proto_err !== 1'b1) begin errs++; $display("FAIL proto_sticky: got %b want 1", proto_err); end
      do_reset();
      chks++; if (proto_err !== 1'b0) begin errs++; $display("FAIL proto_clear: got %b want 0", proto_err); end
   endtask

   initial begin
      rst_n     = 1'b0;
      rsp_ready = '0;
      mul_en    = 1'b1;
      force_mov = 1'b0;
      req_valid = '0;
      req_fp16  = '0;
      req_int4  = '0;
      for (int r = 0; r < NR; r++) begin rsp_cnt[r] = 0; rsp_last[r] = '0; end
      clear_ops();
      test_reset();
      test_single_op();
      test_round_robin();
      test_full();
      test_mixed_signs();
      test_reset_midflight();
      test_proto_err();
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end
endmodule
